// File: rtl/stream_checker_pkg.sv
// Shared types and constants for the rx stream checker: FSM encoding and LFSR definition.
package stream_checker_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StLocked = 2'd1,
        StLost   = 2'd2
    } chk_state_e;

    localparam logic [15:0] LfsrSeed    = 16'hACE1;
    // Taps 16,14,13,11 expressed for a right-shifting register (bits 0,2,3,5)
    localparam logic [15:0] LfsrTapMask = 16'h002D;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {^(s & LfsrTapMask), s[15:1]};
    endfunction

endpackage

// File: rtl/stream_checker_lfsr16.sv
// 16-bit Fibonacci LFSR used to generate pseudo-random backpressure.
module lfsr16
    import stream_checker_pkg::*;
(
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        enable,
    output logic [15:0] state_out
);

    logic [15:0] state_q;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= LfsrSeed;
        end else if (enable) begin
            state_q <= lfsr_step(state_q);
        end
    end

    assign state_out = state_q;

endmodule

// File: rtl/stream_checker.sv
// Checks an incoming valid/ready word stream against an incrementing-counter pattern and
// reports counts, lock status and the last bad word.
module stream_checker
    import stream_checker_pkg::*;
#(
    parameter int unsigned DATA_WIDTH       = 32,
    parameter int unsigned ERR_CNT_WIDTH    = 16,
    parameter int unsigned RELOCK_THRESHOLD = 4,
    parameter int unsigned THROTTLE_EN      = 0
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     valid_in,
    input  logic [DATA_WIDTH-1:0]    data_in,
    output logic                     ready_out,
    input  logic                     clear_in,
    output logic [31:0]              word_count_out,
    output logic [ERR_CNT_WIDTH-1:0] error_count_out,
    output logic                     locked_out,
    output logic                     error_out,
    output logic [DATA_WIDTH-1:0]    last_bad_out
);

    localparam logic [7:0] RelockTh = 8'(RELOCK_THRESHOLD);

    logic                     ready_q;
    chk_state_e               state_q;
    logic [DATA_WIDTH-1:0]    expected_q;
    logic [31:0]              word_count_q;
    logic [ERR_CNT_WIDTH-1:0] error_count_q;
    logic [7:0]               good_run_q;
    logic                     error_q;
    logic                     locked_q;
    logic [DATA_WIDTH-1:0]    last_bad_q;

    logic beat;
    logic match;

    assign beat  = valid_in & ready_q;
    assign match = (data_in == expected_q);

    if (THROTTLE_EN != 0) begin : g_throttle
        logic [15:0] lfsr_state;
        logic        unused_lfsr;

        lfsr16 u_lfsr (
            .clk_in    (clk_in),
            .rst_in    (rst_in),
            .enable    (1'b1),
            .state_out (lfsr_state)
        );

        assign unused_lfsr = ^lfsr_state[15:1];

        always_ff @(posedge clk_in or negedge rst_in) begin
            if (!rst_in) begin
                ready_q <= 1'b0;
            end else begin
                ready_q <= lfsr_state[0];
            end
        end
    end else begin : g_no_throttle
        always_ff @(posedge clk_in or negedge rst_in) begin
            if (!rst_in) begin
                ready_q <= 1'b0;
            end else begin
                ready_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q       <= StIdle;
            expected_q    <= '0;
            word_count_q  <= '0;
            error_count_q <= '0;
            good_run_q    <= '0;
            error_q       <= 1'b0;
            locked_q      <= 1'b0;
            last_bad_q    <= '0;
        end else if (clear_in) begin
            // A beat coinciding with clear is consumed but deliberately ignored
            state_q       <= StIdle;
            expected_q    <= '0;
            word_count_q  <= '0;
            error_count_q <= '0;
            good_run_q    <= '0;
            error_q       <= 1'b0;
            locked_q      <= 1'b0;
            last_bad_q    <= '0;
        end else if (beat) begin
            word_count_q <= word_count_q + 32'd1;
            expected_q   <= data_in + DATA_WIDTH'(1);

            unique case (state_q)
                StIdle: begin
                    state_q  <= StLocked;
                    locked_q <= 1'b1;
                end
                StLocked: begin
                    if (!match) begin
                        state_q    <= StLost;
                        locked_q   <= 1'b0;
                        good_run_q <= '0;
                    end
                end
                StLost: begin
                    if (!match) begin
                        good_run_q <= '0;
                    end else if (good_run_q + 8'd1 == RelockTh) begin
                        state_q    <= StLocked;
                        locked_q   <= 1'b1;
                        good_run_q <= '0;
                    end else begin
                        good_run_q <= good_run_q + 8'd1;
                    end
                end
                default: begin
                    state_q  <= StIdle;
                    locked_q <= 1'b0;
                end
            endcase

            if (state_q != StIdle && !match) begin
                if (error_count_q != '1) begin
                    error_count_q <= error_count_q + ERR_CNT_WIDTH'(1);
                end
                error_q    <= 1'b1;
                last_bad_q <= data_in;
            end
        end
    end

    assign ready_out       = ready_q;
    assign word_count_out  = word_count_q;
    assign error_count_out = error_count_q;
    assign locked_out      = locked_q;
    assign error_out       = error_q;
    assign last_bad_out    = last_bad_q;

endmodule
